// File: rtl/tog_sync_tx.sv
// Source-domain (clkA) transmitter of a toggle-handshake data synchronizer.
// Holds one word on data_out, flips req_tog per word, and retires the word when the synchronized ack_tog parity matches.
module tog_sync_tx #(
    parameter int N           = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TO_W        = 8
) (
    input  logic         clkA,
    input  logic         rst,
    input  logic         enaA,
    input  logic [N-1:0] data_in,
    input  logic         valid_in,
    output logic         ready_out,
    output logic [N-1:0] data_out,
    output logic         req_tog,
    input  logic         ack_tog_in,
    output logic         busy,
    output logic         done_pulse,
    output logic         timeout_err,
    input  logic         clr_err
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    localparam logic [TO_W-1:0] CNT_MAX = '1;

    state_e                 state_q, state_d;
    logic [N-1:0]           data_q, data_d;
    logic                   req_q, req_d;
    logic [TO_W-1:0]        cnt_q, cnt_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ack_sync;

    // The ack synchronizer runs on every edge, even when enaA is low, so a
    // completion that arrived while disabled is visible on the first enabled edge.
    always_ff @(posedge clkA or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ack_tog_in};
        end
    end

    assign ack_sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clkA or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            req_q   <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        req_d   = req_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = err_q;
        if (clr_err) begin
            err_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                // A stray ack toggle while idle is ignored; parity is only judged in WAIT.
                if (valid_in && enaA) begin
                    data_d  = data_in;
                    req_d   = ~req_q;
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (enaA) begin
                    if (ack_sync == req_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        if (cnt_q != CNT_MAX) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                        // Setting overrides a same-cycle clr_err; the transfer keeps waiting.
                        if (cnt_d == CNT_MAX) begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ready_out   = (state_q == IDLE) && enaA;
    assign busy        = (state_q == WAIT);
    assign data_out    = data_q;
    assign req_tog     = req_q;
    assign done_pulse  = done_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_tog_sync_tx.sv
// Bench for tog_sync_tx: directed scenarios plus randomized traffic against a behavioural model.
module tb_tog_sync_tx;

    localparam int N    = 8;
    localparam int SS   = 2;
    localparam int TO_W = 4;
    localparam int MAXW = (1 << TO_W) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         enaA = 1'b1;
    logic [N-1:0] data_in = '0;
    logic         valid_in = 1'b0;
    logic         clr_err = 1'b0;
    logic         ack_tog_in;
    logic         ready_out, req_tog, busy, done_pulse, timeout_err;
    logic [N-1:0] data_out;

    logic man_ack = 1'b0;
    logic echo_ack = 1'b0;
    logic echo_en = 1'b0;
    logic echo_rand = 1'b0;
    int   echo_cnt = 0;
    int   echo_dly = 3;

    int n_checks = 0;
    int n_fail = 0;

    assign ack_tog_in = echo_en ? echo_ack : man_ack;

    always #5 clk = ~clk;

    tog_sync_tx #(.N(N), .SYNC_STAGES(SS), .TO_W(TO_W)) dut (
        .clkA        (clk),
        .rst         (rst),
        .enaA        (enaA),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .ready_out   (ready_out),
        .data_out    (data_out),
        .req_tog     (req_tog),
        .ack_tog_in  (ack_tog_in),
        .busy        (busy),
        .done_pulse  (done_pulse),
        .timeout_err (timeout_err),
        .clr_err     (clr_err)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: one transfer outstanding, ack seen SS edges late.
    logic         m_busy, m_req, m_done, m_err;
    logic [N-1:0] m_data;
    int           m_waited;
    logic         ack_hist[$];

    task automatic model_reset();
        m_busy = 1'b0; m_req = 1'b0; m_done = 1'b0; m_err = 1'b0;
        m_data = '0; m_waited = 0;
        ack_hist.delete();
        for (int i = 0; i < SS; i++) ack_hist.push_back(1'b0);
    endtask

    task automatic model_advance();
        logic seen, set, nd;
        seen = ack_hist[0];
        set = 1'b0;
        nd = 1'b0;
        if (!m_busy) begin
            if (valid_in && enaA) begin
                m_data = data_in; m_req = ~m_req; m_waited = 0; m_busy = 1'b1;
            end
        end else if (enaA) begin
            if (seen == m_req) begin
                m_busy = 1'b0; nd = 1'b1;
            end else begin
                m_waited++;
                if (m_waited >= MAXW) set = 1'b1;
            end
        end
        m_err = set | (m_err & ~clr_err);
        m_done = nd;
        void'(ack_hist.pop_front());
        ack_hist.push_back(ack_tog_in);
    endtask

    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (rst) model_reset();
            check("ready_out", ready_out, m_busy ? 1'b0 : enaA);
            check("busy", busy, m_busy);
            check("data_out", data_out, m_data);
            check("req_tog", req_tog, m_req);
            check("done_pulse", done_pulse, m_done);
            check("timeout_err", timeout_err, m_err);
            if (!rst) model_advance();
        end
    end

    // Far-side responder: returns the request parity after echo_dly cycles.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!echo_en) begin
                echo_ack = man_ack;
                echo_cnt = 0;
            end else if (req_tog != echo_ack) begin
                if (echo_cnt >= echo_dly) begin
                    echo_ack = req_tog;
                    echo_cnt = 0;
                    if (echo_rand) echo_dly = $urandom_range(0, 20);
                end else begin
                    echo_cnt++;
                end
            end else begin
                echo_cnt = 0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst = 1'b1;
        valid_in = 1'b0;
        man_ack = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int dones;
        bit got;

        // Reset then idle
        do_reset();
        check("rst_data", data_out, 8'h00);
        check("rst_req", req_tog, 1'b0);
        check("rst_ready", ready_out, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_err", timeout_err, 1'b0);

        // Single transfer with ack 5 cycles after accept
        data_in = 8'hA5; valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        check("single_data", data_out, 8'hA5);
        check("single_req", req_tog, 1'b1);
        check("single_busy", busy, 1'b1);
        repeat (4) step();
        man_ack = 1'b1;
        step();
        check("single_busy_k", busy, 1'b1);
        step();
        check("single_busy_k1", busy, 1'b1);
        check("single_nodone_k1", done_pulse, 1'b0);
        step();
        check("single_idle", busy, 1'b0);
        check("single_done", done_pulse, 1'b1);
        check("single_ready", ready_out, 1'b1);
        step();
        check("single_done_once", done_pulse, 1'b0);

        // Back-to-back with a 3-cycle echo
        do_reset();
        echo_en = 1'b1; echo_dly = 3;
        data_in = 8'h11; valid_in = 1'b1;
        step();
        check("b2b_req1", req_tog, 1'b1);
        data_in = 8'h22;
        dones = 0;
        for (int i = 0; i < 80 && dones < 2; i++) begin
            if (dones == 0) check("b2b_hold11", data_out, 8'h11);
            step();
            if (done_pulse) dones++;
            if (dones == 1 && busy) valid_in = 1'b0;
        end
        valid_in = 1'b0;
        check("b2b_dones", dones, 2);
        check("b2b_req2", req_tog, 1'b0);
        check("b2b_data22", data_out, 8'h22);
        step();

        // valid_in held during WAIT must be ignored
        data_in = 8'h33; valid_in = 1'b1;
        step();
        data_in = 8'hFF;
        got = 1'b0;
        for (int i = 0; i < 80 && !got; i++) begin
            if (busy) begin
                check("vw_data", data_out, 8'h33);
                check("vw_req", req_tog, 1'b1);
            end
            if (done_pulse) begin
                got = 1'b1;
                valid_in = 1'b0;
            end else begin
                step();
            end
        end
        check("vw_completed", got, 1'b1);
        valid_in = 1'b0;
        step();
        check("vw_no_accept", busy, 1'b0);
        check("vw_req_after", req_tog, 1'b1);

        // Timeout: no ack for 15 WAIT cycles
        man_ack = ack_tog_in;
        echo_en = 1'b0;
        data_in = 8'h5A; valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        check("to_busy", busy, 1'b1);
        repeat (MAXW - 1) step();
        check("to_not_yet", timeout_err, 1'b0);
        step();
        check("to_fired", timeout_err, 1'b1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check("to_set_wins", timeout_err, 1'b1);
        check("to_still_wait", busy, 1'b1);
        man_ack = req_tog;
        repeat (3) step();
        check("to_late_done", done_pulse, 1'b1);
        check("to_late_idle", busy, 1'b0);
        check("to_sticky", timeout_err, 1'b1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check("to_cleared", timeout_err, 1'b0);

        // enaA low in WAIT while the ack arrives
        data_in = 8'h77; valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        step();
        enaA = 1'b0;
        man_ack = ~man_ack;
        for (int i = 0; i < 5; i++) begin
            step();
            check("ena_hold_busy", busy, 1'b1);
            check("ena_hold_nodone", done_pulse, 1'b0);
            check("ena_hold_ready", ready_out, 1'b0);
        end
        enaA = 1'b1;
        step();
        check("ena_done", done_pulse, 1'b1);
        check("ena_idle", busy, 1'b0);

        // Reset in the middle of a transfer
        data_in = 8'h88; valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        step();
        check("mid_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("mid_rst_data", data_out, 8'h00);
        check("mid_rst_req", req_tog, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ready", ready_out, 1'b1);
        check("mid_rst_done", done_pulse, 1'b0);
        man_ack = 1'b0;
        step();
        rst = 1'b0;
        step();

        // Spurious far-side toggle while idle
        man_ack = 1'b1;
        repeat (6) step();
        check("spur_busy", busy, 1'b0);
        check("spur_req", req_tog, 1'b0);
        man_ack = 1'b0;
        repeat (3) step();

        // Randomized traffic with random echo delays (some past the timeout)
        echo_en = 1'b1; echo_rand = 1'b1; echo_dly = 2;
        for (int i = 0; i < 3000; i++) begin
            valid_in = ($urandom % 3) == 0;
            data_in  = N'($urandom);
            enaA     = ($urandom % 8) != 0;
            clr_err  = ($urandom % 16) == 0;
            step();
        end
        valid_in = 1'b0; enaA = 1'b1; clr_err = 1'b0;
        repeat (5) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
